cpu_controller: RTL and testbench

Hardwired control unit for the 8-bit CPU, 16-bit address datapath. Consumes the IR output (`instr`) and the Z flag, and drives every register-load, bus-enable and ALU-select signal of the dataflow. It is a Moore state machine clocked by the gated run clock from the start/stop circuit. It sequences fetch, decode and execute for the 16-instruction set.

---
 rtl/cpu_defs.sv | 91 +++++++++
 rtl/cpu_controller_if.sv | 44 ++++
 rtl/ctrl_sigdec.sv | 129 ++++++++++++
 rtl/cpu_controller.sv | 108 ++++++++++
 tb/tb_cpu_controller.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared encodings for the 8-bit CPU control unit: opcode values, ALU select
// codes, the 29 controller state encodings and the packed control-word type
// that carries every register-load, bus-enable and ALU-select line.
// Ports: none (package).
// -----------------------------------------------------------------------------
package cpu_defs;

    // Opcodes; anything outside 8'h00..8'h0F executes as NOP.
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDAC = 8'h01;
    localparam logic [7:0] OP_STAC = 8'h02;
    localparam logic [7:0] OP_MVAC = 8'h03;
    localparam logic [7:0] OP_MOVR = 8'h04;
    localparam logic [7:0] OP_JUMP = 8'h05;
    localparam logic [7:0] OP_JMPZ = 8'h06;
    localparam logic [7:0] OP_JPNZ = 8'h07;
    localparam logic [7:0] OP_ADD  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_INAC = 8'h0A;
    localparam logic [7:0] OP_CLAC = 8'h0B;
    localparam logic [7:0] OP_AND  = 8'h0C;
    localparam logic [7:0] OP_OR   = 8'h0D;
    localparam logic [7:0] OP_XOR  = 8'h0E;
    localparam logic [7:0] OP_NOT  = 8'h0F;

    // ALU operation select codes.
    localparam logic [4:0] ALUS_PASS = 5'd0;
    localparam logic [4:0] ALUS_ADD  = 5'd4;
    localparam logic [4:0] ALUS_SUB  = 5'd5;
    localparam logic [4:0] ALUS_INC  = 5'd6;
    localparam logic [4:0] ALUS_CLR  = 5'd7;
    localparam logic [4:0] ALUS_AND  = 5'd8;
    localparam logic [4:0] ALUS_OR   = 5'd9;
    localparam logic [4:0] ALUS_XOR  = 5'd10;
    localparam logic [4:0] ALUS_NOT  = 5'd11;

    // Controller states. Encodings 29..31 are unused and recover to FETCH1.
    typedef enum logic [4:0] {
        FETCH1 = 5'd0,  FETCH2 = 5'd1,  FETCH3 = 5'd2,  DECODE = 5'd3,
        LDAC1  = 5'd4,  LDAC2  = 5'd5,  LDAC3  = 5'd6,  LDAC4  = 5'd7,
        LDAC5  = 5'd8,  STAC1  = 5'd9,  STAC2  = 5'd10, STAC3  = 5'd11,
        STAC4  = 5'd12, STAC5  = 5'd13, MVAC1  = 5'd14, MOVR1  = 5'd15,
        JUMP1  = 5'd16, JUMP2  = 5'd17, JUMP3  = 5'd18, SKIP1  = 5'd19,
        SKIP2  = 5'd20, ADD1   = 5'd21, SUB1   = 5'd22, INAC1  = 5'd23,
        CLAC1  = 5'd24, AND1   = 5'd25, OR1    = 5'd26, XOR1   = 5'd27,
        NOT1   = 5'd28
    } state_e;

    // Complete control word driven into the dataflow.
    typedef struct packed {
        logic       arload;
        logic       arinc;
        logic       pcload;
        logic       pcinc;
        logic       drload;
        logic       trload;
        logic       irload;
        logic       rload;
        logic       acload;
        logic       zload;
        logic       pcbus;
        logic       drhbus;
        logic       drlbus;
        logic       trbus;
        logic       rbus;
        logic       acbus;
        logic       membus;
        logic       busmem;
        logic [4:0] alus;
    } ctrl_t;

    // Execute state for the eight single-cycle ALU opcodes (8'h08..8'h0F).
    function automatic state_e alu_state(input logic [2:0] op_lo);
        state_e s;
        case (op_lo)
            3'd0:    s = ADD1;
            3'd1:    s = SUB1;
            3'd2:    s = INAC1;
            3'd3:    s = CLAC1;
            3'd4:    s = AND1;
            3'd5:    s = OR1;
            3'd6:    s = XOR1;
            3'd7:    s = NOT1;
            default: s = FETCH1;
        endcase
        return s;
    endfunction

endpackage : cpu_defs

// File: rtl/cpu_controller_if.sv
// -----------------------------------------------------------------------------
// cpu_controller_if
// Bundle between the control unit and the dataflow.
//   master (controller): reads instr/z, drives all control lines and state.
//   slave  (dataflow)  : drives instr/z, reads all control lines and state.
// -----------------------------------------------------------------------------
interface cpu_controller_if;
    logic [7:0] instr;
    logic       z;
    logic       arload;
    logic       arinc;
    logic       pcload;
    logic       pcinc;
    logic       drload;
    logic       trload;
    logic       irload;
    logic       rload;
    logic       acload;
    logic       zload;
    logic       pcbus;
    logic       drhbus;
    logic       drlbus;
    logic       trbus;
    logic       rbus;
    logic       acbus;
    logic       membus;
    logic       busmem;
    logic [4:0] alus;
    logic [4:0] state;

    modport master (
        input  instr, z,
        output arload, arinc, pcload, pcinc, drload, trload, irload, rload,
               acload, zload, pcbus, drhbus, drlbus, trbus, rbus, acbus,
               membus, busmem, alus, state
    );

    modport slave (
        output instr, z,
        input  arload, arinc, pcload, pcinc, drload, trload, irload, rload,
               acload, zload, pcbus, drhbus, drlbus, trbus, rbus, acbus,
               membus, busmem, alus, state
    );
endinterface : cpu_controller_if

// File: rtl/ctrl_sigdec.sv
// -----------------------------------------------------------------------------
// ctrl_sigdec
// Purely combinational Moore output decode: controller state -> control word.
// Ports:
//   state_i  in   current controller state
//   ctrl_o   out  register loads, bus enables and ALU select for that state
// -----------------------------------------------------------------------------
module ctrl_sigdec
    import cpu_defs::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    // Per-state control decode; everything idle and ALU at PASS unless named.
    always_comb begin
        ctrl_o      = '0;
        ctrl_o.alus = ALUS_PASS;
        case (state_i)
            FETCH1: begin
                ctrl_o.pcbus  = 1'b1;
                ctrl_o.arload = 1'b1;
            end
            FETCH2: begin
                ctrl_o.membus = 1'b1;
                ctrl_o.drload = 1'b1;
                ctrl_o.pcinc  = 1'b1;
            end
            FETCH3: begin
                ctrl_o.drlbus = 1'b1;
                ctrl_o.irload = 1'b1;
                ctrl_o.pcbus  = 1'b1;
                ctrl_o.arload = 1'b1;
            end
            // Address-byte fetch is shared by LDAC and STAC.
            LDAC1, STAC1: begin
                ctrl_o.membus = 1'b1;
                ctrl_o.drload = 1'b1;
                ctrl_o.pcinc  = 1'b1;
                ctrl_o.arinc  = 1'b1;
            end
            LDAC2, STAC2: begin
                ctrl_o.drlbus = 1'b1;
                ctrl_o.trload = 1'b1;
                ctrl_o.membus = 1'b1;
                ctrl_o.drload = 1'b1;
                ctrl_o.pcinc  = 1'b1;
            end
            // DR high byte and TR low byte together form the 16-bit address.
            LDAC3, STAC3: begin
                ctrl_o.drhbus = 1'b1;
                ctrl_o.trbus  = 1'b1;
                ctrl_o.arload = 1'b1;
            end
            LDAC4: begin
                ctrl_o.membus = 1'b1;
                ctrl_o.drload = 1'b1;
            end
            LDAC5: begin
                ctrl_o.drlbus = 1'b1;
                ctrl_o.acload = 1'b1;
            end
            STAC4: begin
                ctrl_o.acbus  = 1'b1;
                ctrl_o.drload = 1'b1;
            end
            STAC5: begin
                ctrl_o.drlbus = 1'b1;
                ctrl_o.busmem = 1'b1;
            end
            MVAC1: begin
                ctrl_o.acbus = 1'b1;
                ctrl_o.rload = 1'b1;
            end
            MOVR1: begin
                ctrl_o.rbus   = 1'b1;
                ctrl_o.acload = 1'b1;
            end
            JUMP1: begin
                ctrl_o.membus = 1'b1;
                ctrl_o.drload = 1'b1;
                ctrl_o.arinc  = 1'b1;
            end
            JUMP2: begin
                ctrl_o.drlbus = 1'b1;
                ctrl_o.trload = 1'b1;
                ctrl_o.membus = 1'b1;
                ctrl_o.drload = 1'b1;
            end
            JUMP3: begin
                ctrl_o.drhbus = 1'b1;
                ctrl_o.trbus  = 1'b1;
                ctrl_o.pcload = 1'b1;
            end
            SKIP1, SKIP2: begin
                ctrl_o.pcinc = 1'b1;
            end
            // Binary ALU ops take their second operand from R.
            ADD1, SUB1, AND1, OR1, XOR1: begin
                ctrl_o.rbus   = 1'b1;
                ctrl_o.acload = 1'b1;
                ctrl_o.zload  = 1'b1;
                case (state_i)
                    ADD1:    ctrl_o.alus = ALUS_ADD;
                    SUB1:    ctrl_o.alus = ALUS_SUB;
                    AND1:    ctrl_o.alus = ALUS_AND;
                    OR1:     ctrl_o.alus = ALUS_OR;
                    XOR1:    ctrl_o.alus = ALUS_XOR;
                    default: ctrl_o.alus = ALUS_PASS;
                endcase
            end
            INAC1, CLAC1, NOT1: begin
                ctrl_o.acload = 1'b1;
                ctrl_o.zload  = 1'b1;
                case (state_i)
                    INAC1:   ctrl_o.alus = ALUS_INC;
                    CLAC1:   ctrl_o.alus = ALUS_CLR;
                    NOT1:    ctrl_o.alus = ALUS_NOT;
                    default: ctrl_o.alus = ALUS_PASS;
                endcase
            end
            default: begin
                ctrl_o      = '0;
                ctrl_o.alus = ALUS_PASS;
            end
        endcase
    end

endmodule : ctrl_sigdec

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
// Hardwired Moore control unit for the 8-bit CPU: sequences fetch, decode and
// execute for the 16-instruction set. Holds the state register and the
// next-state logic; output decode lives in ctrl_sigdec.
// Ports:
//   clk   in   gated run clock (state holds while the CPU is stopped)
//   rst   in   asynchronous active-low reset
//   bus   master side of cpu_controller_if (instr, z in; controls, state out)
// -----------------------------------------------------------------------------
module cpu_controller
    import cpu_defs::*;
(
    input  logic                     clk,
    input  logic                     rst,
    cpu_controller_if.master         bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl_out;

    // State register; reset lands in FETCH1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; final execute states and unused encodings fall back
    // to FETCH1 through the default arm.
    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: state_d = FETCH3;
            FETCH3: state_d = DECODE;
            DECODE: begin
                case (bus.instr)
                    OP_LDAC: state_d = LDAC1;
                    OP_STAC: state_d = STAC1;
                    OP_MVAC: state_d = MVAC1;
                    OP_MOVR: state_d = MOVR1;
                    OP_JUMP: state_d = JUMP1;
                    OP_JMPZ: state_d = bus.z ? JUMP1 : SKIP1;
                    OP_JPNZ: state_d = bus.z ? SKIP1 : JUMP1;
                    OP_ADD, OP_SUB, OP_INAC, OP_CLAC,
                    OP_AND, OP_OR, OP_XOR, OP_NOT:
                        state_d = alu_state(bus.instr[2:0]);
                    default: state_d = FETCH1;   // NOP and undefined opcodes
                endcase
            end
            LDAC1:   state_d = LDAC2;
            LDAC2:   state_d = LDAC3;
            LDAC3:   state_d = LDAC4;
            LDAC4:   state_d = LDAC5;
            STAC1:   state_d = STAC2;
            STAC2:   state_d = STAC3;
            STAC3:   state_d = STAC4;
            STAC4:   state_d = STAC5;
            JUMP1:   state_d = JUMP2;
            JUMP2:   state_d = JUMP3;
            SKIP1:   state_d = SKIP2;
            default: state_d = FETCH1;
        endcase
    end

    ctrl_sigdec u_sigdec (
        .state_i (state_q),
        .ctrl_o  (ctrl_dec)
    );

    // While reset is held the dataflow must see no activity at all, even
    // though the state register already shows FETCH1.
    always_comb begin
        ctrl_out = '0;
        if (!rst) begin
            ctrl_out = '0;
        end else begin
            ctrl_out = ctrl_dec;
        end
    end

    assign bus.arload = ctrl_out.arload;
    assign bus.arinc  = ctrl_out.arinc;
    assign bus.pcload = ctrl_out.pcload;
    assign bus.pcinc  = ctrl_out.pcinc;
    assign bus.drload = ctrl_out.drload;
    assign bus.trload = ctrl_out.trload;
    assign bus.irload = ctrl_out.irload;
    assign bus.rload  = ctrl_out.rload;
    assign bus.acload = ctrl_out.acload;
    assign bus.zload  = ctrl_out.zload;
    assign bus.pcbus  = ctrl_out.pcbus;
    assign bus.drhbus = ctrl_out.drhbus;
    assign bus.drlbus = ctrl_out.drlbus;
    assign bus.trbus  = ctrl_out.trbus;
    assign bus.rbus   = ctrl_out.rbus;
    assign bus.acbus  = ctrl_out.acbus;
    assign bus.membus = ctrl_out.membus;
    assign bus.busmem = ctrl_out.busmem;
    assign bus.alus   = ctrl_out.alus;
    assign bus.state  = state_q;

endmodule : cpu_controller

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
// Scoreboard bench: for each instruction the expected state sequence and the
// control lines of each state are queued, then popped and compared cycle by
// cycle on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cpu_controller;
    import cpu_defs::*;

    typedef struct packed {
        logic       arload, arinc, pcload, pcinc, drload, trload, irload;
        logic       rload, acload, zload, pcbus, drhbus, drlbus, trbus;
        logic       rbus, acbus, membus, busmem;
        logic [4:0] alus;
    } obs_t;

    typedef struct {
        logic [4:0] st;
        obs_t       outs;
    } sb_item_t;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;
    sb_item_t sb[$];

    cpu_controller_if u_if ();

    cpu_controller u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = '{u_if.arload, u_if.arinc, u_if.pcload, u_if.pcinc, u_if.drload,
              u_if.trload, u_if.irload, u_if.rload, u_if.acload, u_if.zload,
              u_if.pcbus, u_if.drhbus, u_if.drlbus, u_if.trbus, u_if.rbus,
              u_if.acbus, u_if.membus, u_if.busmem, u_if.alus};
        return o;
    endfunction

    // Expected control lines per state, written from the instruction tables.
    function automatic obs_t exp_out(input state_e s);
        obs_t o;
        o = '0;
        case (s)
            FETCH1: begin o.pcbus = 1'b1; o.arload = 1'b1; end
            FETCH2: begin o.membus = 1'b1; o.drload = 1'b1; o.pcinc = 1'b1; end
            FETCH3: begin o.drlbus = 1'b1; o.irload = 1'b1; o.pcbus = 1'b1; o.arload = 1'b1; end
            LDAC1, STAC1: begin o.membus = 1'b1; o.drload = 1'b1; o.pcinc = 1'b1; o.arinc = 1'b1; end
            LDAC2, STAC2: begin o.drlbus = 1'b1; o.trload = 1'b1; o.membus = 1'b1; o.drload = 1'b1; o.pcinc = 1'b1; end
            LDAC3, STAC3: begin o.drhbus = 1'b1; o.trbus = 1'b1; o.arload = 1'b1; end
            LDAC4: begin o.membus = 1'b1; o.drload = 1'b1; end
            LDAC5: begin o.drlbus = 1'b1; o.acload = 1'b1; end
            STAC4: begin o.acbus = 1'b1; o.drload = 1'b1; end
            STAC5: begin o.drlbus = 1'b1; o.busmem = 1'b1; end
            MVAC1: begin o.acbus = 1'b1; o.rload = 1'b1; end
            MOVR1: begin o.rbus = 1'b1; o.acload = 1'b1; end
            JUMP1: begin o.membus = 1'b1; o.drload = 1'b1; o.arinc = 1'b1; end
            JUMP2: begin o.drlbus = 1'b1; o.trload = 1'b1; o.membus = 1'b1; o.drload = 1'b1; end
            JUMP3: begin o.drhbus = 1'b1; o.trbus = 1'b1; o.pcload = 1'b1; end
            SKIP1, SKIP2: o.pcinc = 1'b1;
            ADD1:  begin o.rbus = 1'b1; o.alus = 5'd4;  o.acload = 1'b1; o.zload = 1'b1; end
            SUB1:  begin o.rbus = 1'b1; o.alus = 5'd5;  o.acload = 1'b1; o.zload = 1'b1; end
            INAC1: begin                o.alus = 5'd6;  o.acload = 1'b1; o.zload = 1'b1; end
            CLAC1: begin                o.alus = 5'd7;  o.acload = 1'b1; o.zload = 1'b1; end
            AND1:  begin o.rbus = 1'b1; o.alus = 5'd8;  o.acload = 1'b1; o.zload = 1'b1; end
            OR1:   begin o.rbus = 1'b1; o.alus = 5'd9;  o.acload = 1'b1; o.zload = 1'b1; end
            XOR1:  begin o.rbus = 1'b1; o.alus = 5'd10; o.acload = 1'b1; o.zload = 1'b1; end
            NOT1:  begin                o.alus = 5'd11; o.acload = 1'b1; o.zload = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic push_state(input state_e s);
        sb_item_t it;
        it.st   = s;
        it.outs = exp_out(s);
        sb.push_back(it);
    endtask

    // Queue the full expected trace of one instruction, fetch through execute.
    task automatic push_seq(input logic [7:0] op, input logic zz);
        push_state(FETCH1);
        push_state(FETCH2);
        push_state(FETCH3);
        push_state(DECODE);
        case (op)
            8'h01: begin push_state(LDAC1); push_state(LDAC2); push_state(LDAC3);
                         push_state(LDAC4); push_state(LDAC5); end
            8'h02: begin push_state(STAC1); push_state(STAC2); push_state(STAC3);
                         push_state(STAC4); push_state(STAC5); end
            8'h03: push_state(MVAC1);
            8'h04: push_state(MOVR1);
            8'h05: begin push_state(JUMP1); push_state(JUMP2); push_state(JUMP3); end
            8'h06, 8'h07: begin
                if (zz == (op == 8'h06)) begin
                    push_state(JUMP1); push_state(JUMP2); push_state(JUMP3);
                end else begin
                    push_state(SKIP1); push_state(SKIP2);
                end
            end
            8'h08: push_state(ADD1);
            8'h09: push_state(SUB1);
            8'h0A: push_state(INAC1);
            8'h0B: push_state(CLAC1);
            8'h0C: push_state(AND1);
            8'h0D: push_state(OR1);
            8'h0E: push_state(XOR1);
            8'h0F: push_state(NOT1);
            default: ;
        endcase
    endtask

    // Pop one expectation, compare against the DUT now, then move a cycle on.
    task automatic step_one(input string tag);
        sb_item_t it;
        it = sb.pop_front();
        check_val({tag, ".state"}, 32'(u_if.state), 32'(it.st));
        check_val({tag, ".ctrl"},  32'(sample()),   32'(it.outs));
        @(negedge clk);
    endtask

    task automatic run_op(input logic [7:0] op, input logic zz);
        string tag;
        tag = $sformatf("op%02h_z%0d", op, zz);
        u_if.instr = op;
        u_if.z     = zz;
        push_seq(op, zz);
        while (sb.size() > 0) step_one(tag);
    endtask

    initial begin
        n_err      = 0;
        n_chk      = 0;
        rst        = 1'b0;
        u_if.instr = 8'h00;
        u_if.z     = 1'b0;

        // Reset state: FETCH1 encoding, everything quiet, even across edges.
        #2;
        check_val("rst.state", 32'(u_if.state), 32'd0);
        check_val("rst.ctrl",  32'(sample()),   32'd0);
        @(posedge clk);
        #1;
        check_val("rst_hold.state", 32'(u_if.state), 32'd0);
        check_val("rst_hold.ctrl",  32'(sample()),   32'd0);

        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        run_op(8'h00, 1'b0);
        run_op(8'h01, 1'b0);
        run_op(8'h02, 1'b0);
        run_op(8'h03, 1'b0);
        run_op(8'h04, 1'b0);
        run_op(8'h05, 1'b0);
        run_op(8'h06, 1'b0);
        run_op(8'h06, 1'b1);
        run_op(8'h07, 1'b0);
        run_op(8'h07, 1'b1);
        for (int k = 8; k < 16; k++) run_op(8'(k), 1'b1);
        run_op(8'h3A, 1'b1);
        run_op(8'h10, 1'b0);
        run_op(8'hFF, 1'b0);

        // Reset in the middle of LDAC3: immediate return to FETCH1, all quiet.
        u_if.instr = 8'h01;
        u_if.z     = 1'b0;
        push_seq(8'h01, 1'b0);
        repeat (6) step_one("pre_rst");
        begin
            sb_item_t it;
            it = sb.pop_front();
            check_val("ldac3.state", 32'(u_if.state), 32'(it.st));
            check_val("ldac3.ctrl",  32'(sample()),   32'(it.outs));
        end
        sb.delete();
        #1 rst = 1'b0;
        #1;
        check_val("midrst.state", 32'(u_if.state), 32'd0);
        check_val("midrst.ctrl",  32'(sample()),   32'd0);
        @(posedge clk);
        #1;
        check_val("midrst_hold.state", 32'(u_if.state), 32'd0);
        check_val("midrst_hold.ctrl",  32'(sample()),   32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        run_op(8'h01, 1'b0);
        run_op(8'h0F, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_cpu_controller
